ram_fifo_ctrl: RTL and testbench

Synchronous single-clock FIFO controller that sits directly upstream of the 16K block RAM port pair. It turns a push/pop stream interface into the RAM's write-port and read-port signals: write and read addresses, write data, write byte enables and clock enables. It also tracks occupancy and flags, and returns read data with a valid strobe aligned to the RAM read latency.

---
 rtl/ram_fifo_ctrl.sv | 116 +++++++++++
 tb/tb_ram_fifo_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a block RAM write/read port pair.
// Define FIFO_PIPE_RD_EN when the RAM uses its registered read output.
module ram_fifo_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 36,
    parameter int WEN_W  = 4,
    parameter int AF_THR = 2**ADDR_W-4,
    parameter int AE_THR = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Flush,
    input  logic              Push,
    input  logic [DATA_W-1:0] Push_Data,
    input  logic              Pop,
    output logic [DATA_W-1:0] Pop_Data,
    output logic              Pop_Valid,
    output logic              Full,
    output logic              Empty,
    output logic              Almost_Full,
    output logic              Almost_Empty,
    output logic [ADDR_W:0]   Level,
    output logic              Overflow,
    output logic              Underflow,
    output logic [ADDR_W-1:0] WA,
    output logic [ADDR_W-1:0] RA,
    output logic [DATA_W-1:0] WD,
    output logic [WEN_W-1:0]  WEN,
    output logic              WClk_En,
    output logic              RClk_En,
    input  logic [DATA_W-1:0] RD
);

`ifdef FIFO_PIPE_RD_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    localparam logic [ADDR_W:0] AF_L = (ADDR_W+1)'(AF_THR);
    localparam logic [ADDR_W:0] AE_L = (ADDR_W+1)'(AE_THR);

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic full_w, empty_w, push_ok, pop_ok;

    assign full_w  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                     (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign empty_w = (wr_ptr_q == rd_ptr_q);

    // Rst_n gates the strobes so the RAM sees no enables during reset
    assign push_ok = Rst_n && !Flush && Push && !full_w;
    assign pop_ok  = Rst_n && !Flush && Pop && !empty_w;

    assign WA      = wr_ptr_q[ADDR_W-1:0];
    assign RA      = rd_ptr_q[ADDR_W-1:0];
    assign WD      = Push_Data;
    assign WEN     = {WEN_W{push_ok}};
    assign WClk_En = push_ok;
    assign RClk_En = pop_ok;

    assign Full         = full_w;
    assign Empty        = empty_w;
    assign Level        = wr_ptr_q - rd_ptr_q;
    assign Almost_Full  = (Level >= AF_L);
    assign Almost_Empty = (Level <= AE_L);
    assign Overflow     = ovf_q;
    assign Underflow    = udf_q;

    assign Pop_Valid = vld_q[RD_LAT-1];
    assign Pop_Data  = Pop_Valid ? RD : hold_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, pop_ok};
        ovf_d    = ovf_q | (Push && full_w);
        udf_d    = udf_q | (Pop && empty_w);
        hold_d   = Pop_Valid ? RD : hold_q;
`ifdef FIFO_PIPE_RD_EN
        vld_d    = {vld_q[0], pop_ok};
`else
        vld_d    = pop_ok;
`endif
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
            vld_d    = '0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            vld_q    <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            vld_q    <= vld_d;
            hold_q   <= hold_d;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomized bench for ram_fifo_ctrl with a queue-based reference
// model and a behavioural RAM attached to the controller ports.
module tb_ram_fifo_ctrl;

    localparam int AW  = 4;
    localparam int DW  = 36;
    localparam int WW  = 4;
    localparam int DEP = 16;
`ifdef FIFO_PIPE_RD_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          Clk, Rst_n, Flush, Push, Pop;
    logic [DW-1:0] Push_Data, Pop_Data, WD, RD;
    logic          Pop_Valid, Full, Empty, Almost_Full, Almost_Empty;
    logic [AW:0]   Level;
    logic          Overflow, Underflow, WClk_En, RClk_En;
    logic [AW-1:0] WA, RA;
    logic [WW-1:0] WEN;

    ram_fifo_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .WEN_W(WW), .AF_THR(12), .AE_THR(4)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
        .Push(Push), .Push_Data(Push_Data),
        .Pop(Pop), .Pop_Data(Pop_Data), .Pop_Valid(Pop_Valid),
        .Full(Full), .Empty(Empty),
        .Almost_Full(Almost_Full), .Almost_Empty(Almost_Empty),
        .Level(Level), .Overflow(Overflow), .Underflow(Underflow),
        .WA(WA), .RA(RA), .WD(WD), .WEN(WEN),
        .WClk_En(WClk_En), .RClk_En(RClk_En), .RD(RD)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural block RAM
    logic [DW-1:0] mem [DEP];
    logic [DW-1:0] rd_q, rd_q2;
    always @(posedge Clk) begin
        if (WClk_En && WEN == '1) mem[WA] <= WD;
        if (RClk_En) rd_q <= mem[RA];
        rd_q2 <= rd_q;
    end
`ifdef FIFO_PIPE_RD_EN
    assign RD = rd_q2;
`else
    assign RD = rd_q;
`endif

    // Reference model state
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } pend_t;

    logic [DW-1:0] q [$];
    pend_t         pq [$];
    logic [DW-1:0] last;
    int            wcnt, rcnt, cyc;
    logic          e_ovf, e_udf;
    int            n_tests, n_fail;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pq.delete();
        last  = '0;
        wcnt  = 0;
        rcnt  = 0;
        e_ovf = 1'b0;
        e_udf = 1'b0;
    endtask

    task automatic step(input logic pu, input logic po,
                        input logic fl, input logic [DW-1:0] d);
        int            sz;
        logic          acc_w, acc_r, e_v;
        logic [DW-1:0] e_pd;
        Push = pu; Pop = po; Flush = fl; Push_Data = d;
        @(negedge Clk);
        sz    = q.size();
        acc_w = pu && !fl && sz < DEP;
        acc_r = po && !fl && sz > 0;
        e_v   = pq.size() > 0 && pq[0].due == cyc;
        e_pd  = e_v ? pq[0].data : last;
        check("full",  64'(Full),         64'(sz == DEP));
        check("empty", 64'(Empty),        64'(sz == 0));
        check("afull", 64'(Almost_Full),  64'(sz >= 12));
        check("aempt", 64'(Almost_Empty), 64'(sz <= 4));
        check("level", 64'(Level),        64'(sz));
        check("ovf",   64'(Overflow),     64'(e_ovf));
        check("udf",   64'(Underflow),    64'(e_udf));
        check("wclk",  64'(WClk_En),      64'(acc_w));
        check("wen",   64'(WEN),          acc_w ? 64'hF : 64'h0);
        check("rclk",  64'(RClk_En),      64'(acc_r));
        check("wa",    64'(WA),           64'(wcnt % DEP));
        check("ra",    64'(RA),           64'(rcnt % DEP));
        check("wd",    64'(WD),           64'(d));
        check("pvld",  64'(Pop_Valid),    64'(e_v));
        check("pdata", 64'(Pop_Data),     64'(e_pd));
        @(posedge Clk);
        if (e_v) begin
            last = pq[0].data;
            void'(pq.pop_front());
        end
        if (fl) begin
            q.delete();
            pq.delete();
            wcnt  = 0;
            rcnt  = 0;
            e_ovf = 1'b0;
            e_udf = 1'b0;
        end else begin
            if (pu && sz == DEP) e_ovf = 1'b1;
            if (po && sz == 0)   e_udf = 1'b1;
            if (acc_r) begin
                pq.push_back('{due: cyc + LAT, data: q.pop_front()});
                rcnt++;
            end
            if (acc_w) begin
                q.push_back(d);
                wcnt++;
            end
        end
        cyc++;
        #1;
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom(), $urandom()});
    endfunction

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        model_reset();
        Rst_n = 1'b0; Flush = 0; Push = 1; Pop = 1; Push_Data = '0;
        #12;
        check("rst_empty", 64'(Empty),     64'd1);
        check("rst_level", 64'(Level),     64'd0);
        check("rst_wclk",  64'(WClk_En),   64'd0);
        check("rst_rclk",  64'(RClk_En),   64'd0);
        check("rst_pvld",  64'(Pop_Valid), 64'd0);
        Push = 0; Pop = 0;
        #5 Rst_n = 1'b1;
        @(posedge Clk); #1;

        repeat (3) step(0, 0, 0, '0);
        step(0, 1, 0, '0);
        step(0, 0, 0, '0);
        step(0, 0, 1, '0);

        for (int i = 1; i <= 17; i++) step(1, 0, 0, DW'(i));
        step(0, 0, 0, '0);
        step(1, 1, 0, 36'h2A);
        step(1, 0, 0, 36'h11);
        repeat (16) step(0, 1, 0, '0);
        repeat (3) step(0, 0, 0, '0);

        step(1, 1, 0, 36'h55);
        step(0, 0, 1, '0);

        for (int i = 0; i < 3; i++) step(1, 0, 0, rnd());
        for (int i = 0; i < 40; i++) step(1, 1, 0, rnd());
        repeat (3) step(0, 0, 0, '0);

        step(0, 1, 0, '0);
        step(0, 1, 0, '0);
        step(0, 0, 1, '0);
        repeat (3) step(0, 0, 0, '0);

        for (int i = 0; i < 3000; i++) begin
            int p;
            p = 25 * (((i / 150) % 3) + 1);
            step($urandom_range(99) < p,
                 $urandom_range(99) < (100 - p),
                 $urandom_range(127) == 0,
                 rnd());
        end

        for (int i = 0; i < 4; i++) step(1, 0, 0, rnd());
        step(0, 1, 0, '0);
        Push = 1; Pop = 1; Rst_n = 1'b0;
        #1;
        check("arst_pvld",  64'(Pop_Valid), 64'd0);
        check("arst_pdata", 64'(Pop_Data),  64'd0);
        check("arst_empty", 64'(Empty),     64'd1);
        check("arst_level", 64'(Level),     64'd0);
        check("arst_wclk",  64'(WClk_En),   64'd0);
        check("arst_rclk",  64'(RClk_En),   64'd0);
        check("arst_flags", 64'({Overflow, Underflow, Full}), 64'd0);
        model_reset();
        Push = 0; Pop = 0;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        cyc++;
        repeat (4) step(0, 0, 0, '0);
        step(1, 0, 0, 36'h123456789);
        step(0, 1, 0, '0);
        repeat (3) step(0, 0, 0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
